// File: rtl/rotary_encoder_decoder.sv
// Quadrature rotary encoder front end: per-phase synchronizer and debouncer,
// full-detent decoder with illegal-transition detection, and a position
// counter with optional wrap or saturation plus a synchronous preset.
module rotary_encoder_decoder #(
  parameter int unsigned       WIDTH           = 8,
  parameter int unsigned       DEBOUNCE_CYCLES = 16,
  parameter int unsigned       WRAP            = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] value,
  output logic             up_pulse,
  output logic             down_pulse,
  output logic             error
);

  localparam logic [7:0]        RunMax   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0]  ValueMax = '1;
  localparam logic signed [3:0] AccMax   = 4'sd4;
  localparam logic signed [3:0] AccMin   = -4'sd4;

  typedef enum logic [0:0] {StUnarmed, StArmed} state_e;

  // Bit 1 carries phase A, bit 0 phase B throughout.
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       accepted_q;
  logic [1:0][7:0]  run_cnt_q;
  logic [7:0]       arm_cnt_q;
  state_e           state_q, state_d;
  logic [1:0]       prev_q, prev_d;
  logic signed [3:0] accum_q, accum_d, accum_step;
  logic             up_q, down_q, error_q;
  logic             up_d, down_d, error_d;
  logic [WIDTH-1:0] value_q;
  logic             stable, arm_now, fwd, bwd;

  // Two-flop synchronizer for both pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {enc_a, enc_b};
      sync2_q <= sync1_q;
    end
  end

  // Per-phase debouncer: accept a new level after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge clk) begin
    if (reset) begin
      accepted_q <= '0;
      run_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == accepted_q[i]) begin
          run_cnt_q[i] <= '0;
        end else if (run_cnt_q[i] == RunMax) begin
          accepted_q[i] <= sync2_q[i];
          run_cnt_q[i]  <= '0;
        end else begin
          run_cnt_q[i] <= run_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign stable  = (sync2_q == accepted_q);
  assign arm_now = (state_q == StUnarmed) && stable && (arm_cnt_q == RunMax);

  // Counts consecutive cycles with both phases settled while waiting to arm.
  always_ff @(posedge clk) begin
    if (reset || (state_q == StArmed) || !stable) begin
      arm_cnt_q <= '0;
    end else begin
      arm_cnt_q <= arm_cnt_q + 8'd1;
    end
  end

  // Decoder state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StUnarmed;
    end else begin
      state_q <= state_d;
    end
  end

  // Decoder next state: arm once after the first fully settled window.
  always_comb begin
    state_d = state_q;
    if (arm_now) begin
      state_d = StArmed;
    end
  end

  // Classify the accepted-state change as a forward or backward single step.
  always_comb begin
    fwd = 1'b0;
    bwd = 1'b0;
    case ({prev_q, accepted_q})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: bwd = 1'b1;
      default: ;
    endcase
  end

  // Decoder outputs: accumulate sub-steps, emit detent or error strobes.
  always_comb begin
    prev_d     = prev_q;
    accum_d    = accum_q;
    accum_step = accum_q;
    up_d       = 1'b0;
    down_d     = 1'b0;
    error_d    = 1'b0;
    if (state_q == StUnarmed) begin
      if (arm_now) begin
        prev_d = accepted_q;
      end
    end else if (accepted_q != prev_q) begin
      prev_d = accepted_q;
      if (fwd) begin
        accum_step = (accum_q == AccMax) ? accum_q : accum_q + 4'sd1;
      end else if (bwd) begin
        accum_step = (accum_q == AccMin) ? accum_q : accum_q - 4'sd1;
      end
      if (!fwd && !bwd) begin
        // Both phases moved at once: direction unknown, resynchronise.
        error_d = 1'b1;
        accum_d = '0;
      end else if (accepted_q == 2'b00) begin
        up_d    = (accum_step == AccMax);
        down_d  = (accum_step == AccMin);
        accum_d = '0;
      end else begin
        accum_d = accum_step;
      end
    end
  end

  // Decoder data registers and output strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= '0;
      accum_q <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      accum_q <= accum_d;
      up_q    <= up_d;
      down_q  <= down_d;
      error_q <= error_d;
    end
  end

  // Position counter: preset wins over a same-cycle step.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= RESET_VALUE;
    end else if (load) begin
      value_q <= load_data;
    end else if (up_d) begin
      if ((WRAP != 0) || (value_q != ValueMax)) begin
        value_q <= value_q + WIDTH'(1);
      end
    end else if (down_d) begin
      if ((WRAP != 0) || (value_q != '0)) begin
        value_q <= value_q - WIDTH'(1);
      end
    end
  end

  assign value      = value_q;
  assign up_pulse   = up_q;
  assign down_pulse = down_q;
  assign error      = error_q;

endmodule

// File: tb/tb_rotary_encoder_decoder.sv
// Bench for rotary_encoder_decoder: a wrapping and a saturating instance share
// stimulus; a history-based reference model is compared every cycle, and a
// table of hand-derived scenarios checks pulse counts and final values.
module tb_rotary_encoder_decoder;

  localparam int         D   = 4;
  localparam logic [7:0] RvW = 8'h00;
  localparam logic [7:0] RvS = 8'h80;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic [7:0] value_w, value_s;
  logic       up_w, down_w, err_w, up_s, down_s, err_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rotary_encoder_decoder #(
    .WIDTH(8), .DEBOUNCE_CYCLES(D), .WRAP(1), .RESET_VALUE(RvW)
  ) dut_w (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .load(load),
    .load_data(load_data), .value(value_w), .up_pulse(up_w), .down_pulse(down_w),
    .error(err_w)
  );

  rotary_encoder_decoder #(
    .WIDTH(8), .DEBOUNCE_CYCLES(D), .WRAP(0), .RESET_VALUE(RvS)
  ) dut_s (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .load(load),
    .load_data(load_data), .value(value_s), .up_pulse(up_s), .down_pulse(down_s),
    .error(err_s)
  );

  // Reference model state
  logic [1:0] m_s1 = '0, m_s2 = '0, m_acc = '0, m_prev = '0;
  bit         m_armed = 1'b0;
  int         m_accum = 0;
  logic [1:0] sync_hist[$];
  bit         stable_hist[$];
  bit         m_up = 0, m_down = 0, m_err = 0;
  logic [7:0] m_vw = RvW, m_vs = RvS;

  function automatic int pos_of(logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One rising edge of the reference model, using the inputs the DUT sampled.
  task automatic model_edge();
    logic [1:0] used, new_acc;
    bit nu, nd, ne, all_true, all_diff;
    int d;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_acc = '0; m_prev = '0; m_armed = 0; m_accum = 0;
      sync_hist.delete(); stable_hist.delete();
      m_up = 0; m_down = 0; m_err = 0; m_vw = RvW; m_vs = RvS;
      return;
    end
    used = m_s2; nu = 0; nd = 0; ne = 0; new_acc = m_acc;
    if (!m_armed) begin
      stable_hist.push_back(used == m_acc);
      if (stable_hist.size() > D) void'(stable_hist.pop_front());
      all_true = (stable_hist.size() == D);
      foreach (stable_hist[k]) if (!stable_hist[k]) all_true = 0;
      if (all_true) begin
        m_armed = 1;
        m_prev  = m_acc;
      end
    end else if (m_acc != m_prev) begin
      d = (pos_of(m_acc) - pos_of(m_prev) + 4) % 4;
      if (d == 2) begin
        ne = 1;
        m_accum = 0;
      end else begin
        m_accum += (d == 1) ? 1 : -1;
        if (m_acc == 2'b00) begin
          nu = (m_accum >= 4);
          nd = (m_accum <= -4);
          m_accum = 0;
        end
      end
      m_prev = m_acc;
    end
    // Accepted level flips once the last D synchronized samples all disagree with it.
    sync_hist.push_back(used);
    if (sync_hist.size() > D) void'(sync_hist.pop_front());
    for (int i = 0; i < 2; i++) begin
      all_diff = (sync_hist.size() == D);
      foreach (sync_hist[k]) if (sync_hist[k][i] == m_acc[i]) all_diff = 0;
      if (all_diff) new_acc[i] = ~m_acc[i];
    end
    if (load) begin
      m_vw = load_data;
      m_vs = load_data;
    end else if (nu) begin
      m_vw = m_vw + 8'd1;
      if (m_vs != 8'hFF) m_vs = m_vs + 8'd1;
    end else if (nd) begin
      m_vw = m_vw - 8'd1;
      if (m_vs != 8'h00) m_vs = m_vs - 8'd1;
    end
    m_s2 = m_s1;
    m_s1 = {enc_a, enc_b};
    m_acc = new_acc;
    m_up = nu; m_down = nd; m_err = ne;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("up_w", up_w, m_up);
    check("down_w", down_w, m_down);
    check("err_w", err_w, m_err);
    check("up_s", up_s, m_up);
    check("down_s", down_s, m_down);
    check("err_s", err_s, m_err);
    check("value_w", value_w, m_vw);
    check("value_s", value_s, m_vs);
  endtask

  typedef struct {
    logic [1:0] pins;
    int         hold;
    bit         rst;
    bit         ld;
    logic [7:0] ld_data;
    int         exp_up;
    int         exp_down;
    int         exp_err;
    logic [7:0] exp_vw;
    logic [7:0] exp_vs;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic [1:0] p, int h, bit r, bit l, logic [7:0] ldd,
                              int u, int dn, int e, logic [7:0] vw, logic [7:0] vs);
    vec_t v;
    v.pins = p; v.hold = h; v.rst = r; v.ld = l; v.ld_data = ldd;
    v.exp_up = u; v.exp_down = dn; v.exp_err = e; v.exp_vw = vw; v.exp_vs = vs;
    vecs.push_back(v);
  endfunction

  initial begin
    int nu_w, nd_w, ne_w, nu_s, nd_s, ne_s;
    int hold;
    logic [1:0] pins;

    // Reset, arm at 00, one forward detent then one backward detent
    add(2'b00, 3, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h80);
    add(2'b00, 10, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h80);
    add(2'b10, 8, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h80);
    add(2'b11, 8, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h80);
    add(2'b01, 8, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h80);
    add(2'b00, 8, 0, 0, 8'h00, 1, 0, 0, 8'h01, 8'h81);
    add(2'b01, 8, 0, 0, 8'h00, 0, 0, 0, 8'h01, 8'h81);
    add(2'b11, 8, 0, 0, 8'h00, 0, 0, 0, 8'h01, 8'h81);
    add(2'b10, 8, 0, 0, 8'h00, 0, 0, 0, 8'h01, 8'h81);
    add(2'b00, 8, 0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h80);
    // Three-cycle glitch on A is rejected
    add(2'b10, 3, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h80);
    add(2'b00, 8, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h80);
    // Double-phase jump, then a partial rotation back to 00
    add(2'b11, 8, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h80);
    add(2'b01, 8, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h80);
    add(2'b00, 8, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h80);
    // Preset to max then forward: wrap vs saturate
    add(2'b00, 1, 0, 1, 8'hFF, 0, 0, 0, 8'hFF, 8'hFF);
    add(2'b10, 8, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 8'hFF);
    add(2'b11, 8, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 8'hFF);
    add(2'b01, 8, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 8'hFF);
    add(2'b00, 8, 0, 0, 8'h00, 1, 0, 0, 8'h00, 8'hFF);
    // Load on the exact edge the up pulse fires (D+2 edges after the pin change)
    add(2'b10, 8, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF);
    add(2'b11, 8, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF);
    add(2'b01, 8, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF);
    add(2'b00, D + 2, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF);
    add(2'b00, 1, 0, 1, 8'h40, 1, 0, 0, 8'h40, 8'h40);
    add(2'b00, 8, 0, 0, 8'h00, 0, 0, 0, 8'h40, 8'h40);
    // Reset mid-rotation discards the partial step
    add(2'b10, 8, 0, 0, 8'h00, 0, 0, 0, 8'h40, 8'h40);
    add(2'b11, 8, 0, 0, 8'h00, 0, 0, 0, 8'h40, 8'h40);
    add(2'b11, 2, 1, 1, 8'h33, 0, 0, 0, 8'h00, 8'h80);
    add(2'b11, 16, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h80);
    add(2'b01, 8, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h80);
    add(2'b00, 8, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h80);
    // Backward detent from zero: wrap to FF vs plain decrement
    add(2'b01, 8, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h80);
    add(2'b11, 8, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h80);
    add(2'b10, 8, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h80);
    add(2'b00, 8, 0, 0, 8'h00, 0, 1, 0, 8'hFF, 8'h7F);

    foreach (vecs[i]) begin
      enc_a = vecs[i].pins[1];
      enc_b = vecs[i].pins[0];
      reset = vecs[i].rst;
      load = vecs[i].ld;
      load_data = vecs[i].ld_data;
      nu_w = 0; nd_w = 0; ne_w = 0; nu_s = 0; nd_s = 0; ne_s = 0;
      repeat (vecs[i].hold) begin
        cycle();
        nu_w += int'(up_w); nd_w += int'(down_w); ne_w += int'(err_w);
        nu_s += int'(up_s); nd_s += int'(down_s); ne_s += int'(err_s);
      end
      reset = 1'b0;
      load = 1'b0;
      check($sformatf("row%0d up_w", i), nu_w, vecs[i].exp_up);
      check($sformatf("row%0d down_w", i), nd_w, vecs[i].exp_down);
      check($sformatf("row%0d err_w", i), ne_w, vecs[i].exp_err);
      check($sformatf("row%0d up_s", i), nu_s, vecs[i].exp_up);
      check($sformatf("row%0d down_s", i), nd_s, vecs[i].exp_down);
      check($sformatf("row%0d err_s", i), ne_s, vecs[i].exp_err);
      check($sformatf("row%0d value_w", i), value_w, vecs[i].exp_vw);
      check($sformatf("row%0d value_s", i), value_s, vecs[i].exp_vs);
    end

    // Random pin activity with glitches, presets and occasional reset
    for (int seg = 0; seg < 1500; seg++) begin
      pins = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 12);
      enc_a = pins[1];
      enc_b = pins[0];
      for (int c = 0; c < hold; c++) begin
        load = ($urandom_range(0, 39) == 0);
        load_data = 8'($urandom);
        reset = ($urandom_range(0, 399) == 0);
        cycle();
      end
      load = 1'b0;
      reset = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rotary_encoder_decoder.md
ROTARY_ENCODER_DECODER -- requirements
Module: rotary_encoder_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of value.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept a pin level (range 2..255).
REQ-003 SHALL have parameter WRAP, default 1: 1 = value wraps modulo 2^WIDTH; 0 = value saturates at 0 and 2^WIDTH-1.
REQ-004 SHALL have parameter RESET_VALUE, default 0: value after reset.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 enc_a  input  1  encoder phase A, asynchronous pin.
REQ-008 enc_b  input  1  encoder phase B, asynchronous pin.
REQ-009 load  input  1  synchronous preset strobe for value.
REQ-010 load_data  input  WIDTH  preset data.
REQ-011 value  output  WIDTH  registered position count.
REQ-012 up_pulse  output  1  one-cycle strobe, one full detent forward.
REQ-013 down_pulse  output  1  one-cycle strobe, one full detent backward.
REQ-014 error  output  1  one-cycle strobe, illegal quadrature transition.

Function
REQ-015 enc_a, enc_b SHALL each pass a 2-flop synchronizer before any other logic.
REQ-016 Per phase, debouncer SHALL update its accepted level only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the accepted level clears the run counter.
REQ-017 Pin change sampled at edge n SHALL appear in the accepted level at edge n+1+DEBOUNCE_CYCLES; pulses/value SHALL update at edge n+2+DEBOUNCE_CYCLES.
REQ-018 After reset, decoder SHALL be UNARMED; first time both phases have been stable DEBOUNCE_CYCLES cycles, the accepted state SHALL be captured as previous state, decoder becomes ARMED, no pulse emitted.
REQ-019 Accepted state {A,B}: forward sequence 00->10->11->01->00; backward the reverse.
REQ-020 Signed sub-step accumulator (range -4..+4) SHALL +1 per forward transition, -1 per backward transition.
REQ-021 On entering 00: accumulator reaching +4 SHALL assert up_pulse; reaching -4 SHALL assert down_pulse; accumulator SHALL then clear to 0 regardless of value.
REQ-022 Partial rotation reversed back to 00 (accumulator not +/-4) SHALL produce no pulse.
REQ-023 Transition changing both phases in one accepted update SHALL assert error for one cycle, clear accumulator, adopt new state as previous, emit no up/down pulse.
REQ-024 up_pulse SHALL increment value, down_pulse decrement, same edge as the pulse.
REQ-025 WRAP=1: 2^WIDTH-1 +1 -> 0, 0 -1 -> 2^WIDTH-1; WRAP=0: value held at bound, pulse still asserted.
REQ-026 load=1 SHALL set value to load_data next edge; load overrides a simultaneous step; accumulator and decoder state unaffected.
REQ-027 up_pulse, down_pulse, error SHALL be mutually exclusive and never asserted for two consecutive cycles from one transition.

Reset
REQ-028 reset SHALL set value=RESET_VALUE, up_pulse=down_pulse=error=0, synchronizers and accepted levels=0, run counters=0, accumulator=0, decoder UNARMED.
REQ-029 reset SHALL override load and any in-progress transition; reset mid-rotation SHALL discard partial accumulator.

Verification (WIDTH=8, DEBOUNCE_CYCLES=4)
REQ-030 Pins 00 after reset, then 10,11,01,00 each held 8 cycles, value 0x00 -> exactly one up_pulse, value 0x01; reverse sequence -> one down_pulse, value 0x00.
REQ-031 WRAP=1, load 0xFF, one forward detent -> value 0x00; WRAP=0 same -> value 0xFF, up_pulse asserted once.
REQ-032 enc_a glitch high 3 cycles between stable 00 periods -> no accepted change, no pulses, value unchanged.
REQ-033 Pins 00 -> 11 in one step, held 8 cycles -> error asserted one cycle, no up/down pulse, value unchanged.
REQ-034 load=1, load_data=0x40 on the exact edge an up_pulse is generated -> value 0x40.
REQ-035 Reset asserted after 00->10->11, released, then 01->00 -> no pulse (UNARMED capture then partial step), value RESET_VALUE.
